// File: rtl/mem_2p_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_2p_ctrl_pkg : shared power-state codes for the 2-port SRAM ctrl   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package mem_2p_ctrl_pkg;

  typedef enum logic [2:0] {
    PWR_ACTIVE = 3'd0,
    PWR_LS     = 3'd1,
    PWR_DS     = 3'd2,
    PWR_SD     = 3'd3,
    PWR_WAKE   = 3'd4
  } pwr_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_2p_pwr_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_2p_pwr_fsm : idle/wake counters and ls/ds/sd pin sequencing       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module mem_2p_pwr_fsm
  import mem_2p_ctrl_pkg::*;
#(
  parameter int LS_IDLE = 8,
  parameter int DS_IDLE = 64,
  parameter int DS_WAKE = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_any_req,
  input  logic       i_sd_req,
  output pwr_state_e o_state,
  output logic       o_ls,
  output logic       o_ds,
  output logic       o_sd,
  output logic       o_mem_lost
);

  localparam int IW = $clog2(((LS_IDLE > DS_IDLE) ? LS_IDLE : DS_IDLE) + 1);
  localparam int WW = $clog2(DS_WAKE + 1);
  localparam logic [IW-1:0] C_LS_LAST   = IW'(LS_IDLE - 1);
  localparam logic [IW-1:0] C_DS_LAST   = IW'(DS_IDLE - 1);
  localparam logic [IW-1:0] C_IDLE_ONE  = IW'(1);
  localparam logic [WW-1:0] C_WAKE_INIT = WW'(DS_WAKE);
  localparam logic [WW-1:0] C_WAKE_ONE  = WW'(1);

  pwr_state_e    r_state;
  logic [IW-1:0] r_idle_cnt;
  logic [WW-1:0] r_wake_cnt;
  logic          r_ls, r_ds, r_sd, r_mem_lost;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= PWR_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_ls       <= 1'b0;
      r_ds       <= 1'b0;
      r_sd       <= 1'b0;
      r_mem_lost <= 1'b0;
    end else begin
      r_mem_lost <= 1'b0;
      case (r_state)
        PWR_ACTIVE: begin
          // SD only on a request-free cycle so the macro never sees me=1 at entry
          if (i_sd_req && !i_any_req) begin
            r_state    <= PWR_SD;
            r_sd       <= 1'b1;
            r_idle_cnt <= '0;
          end else if (i_any_req) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == C_LS_LAST) begin
            r_state    <= PWR_LS;
            r_ls       <= 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + C_IDLE_ONE;
          end
        end
        PWR_LS: begin
          if (i_sd_req) begin
            r_state <= PWR_SD;
            r_ls    <= 1'b0;
            r_sd    <= 1'b1;
          end else if (i_any_req) begin
            r_state    <= PWR_WAKE;
            r_ls       <= 1'b0;
            r_wake_cnt <= C_WAKE_ONE;
          end else if (r_idle_cnt == C_DS_LAST) begin
            r_state    <= PWR_DS;
            r_ls       <= 1'b0;
            r_ds       <= 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + C_IDLE_ONE;
          end
        end
        PWR_DS: begin
          if (i_sd_req) begin
            r_state <= PWR_SD;
            r_ds    <= 1'b0;
            r_sd    <= 1'b1;
          end else if (i_any_req) begin
            r_state    <= PWR_WAKE;
            r_ds       <= 1'b0;
            r_wake_cnt <= C_WAKE_INIT;
          end
        end
        PWR_SD: begin
          if (!i_sd_req) begin
            r_state    <= PWR_WAKE;
            r_sd       <= 1'b0;
            r_wake_cnt <= C_WAKE_INIT;
            r_mem_lost <= 1'b1;
          end
        end
        PWR_WAKE: begin
          r_wake_cnt <= r_wake_cnt - C_WAKE_ONE;
          if (r_wake_cnt == C_WAKE_ONE) begin
            r_state    <= PWR_ACTIVE;
            r_idle_cnt <= '0;
          end
        end
        default: begin
          r_state <= PWR_ACTIVE;
          r_ls    <= 1'b0;
          r_ds    <= 1'b0;
          r_sd    <= 1'b0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_ls       = r_ls;
  assign o_ds       = r_ds;
  assign o_sd       = r_sd;
  assign o_mem_lost = r_mem_lost;

endmodule
`default_nettype wire

// File: rtl/mem_2p_arb_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_2p_arb_ctrl : contention arbiter + power sequencer for a 2p SRAM  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module mem_2p_arb_ctrl
  import mem_2p_ctrl_pkg::*;
#(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int LS_IDLE = 8,
  parameter int DS_IDLE = 64,
  parameter int DS_WAKE = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  input  logic [DW-1:0] c0_wmask,
  output logic          c0_gnt,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  input  logic [DW-1:0] c1_wmask,
  output logic          c1_gnt,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  input  logic          sd_req,
  output logic          mem_lost,
  output logic [2:0]    pwr_state,
  output logic          mea,
  output logic          rwa,
  output logic [AW-1:0] wadra,
  output logic [AW-1:0] radra,
  output logic [DW-1:0] da,
  output logic [DW-1:0] wma,
  output logic          meb,
  output logic          rwb,
  output logic [AW-1:0] wadrb,
  output logic [AW-1:0] radrb,
  output logic [DW-1:0] db,
  output logic [DW-1:0] wmb,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  output logic          ls,
  output logic          ds,
  output logic          sd
);

  pwr_state_e    w_state;
  logic          w_active, w_any_req, w_conflict;
  logic          r_rr_ptr, r_rvalid0, r_rvalid1;
  logic          r_rwa, r_rwb;
  logic [AW-1:0] r_adra, r_adrb;
  logic [DW-1:0] r_da, r_db, r_wma, r_wmb;

  mem_2p_pwr_fsm #(
    .LS_IDLE (LS_IDLE),
    .DS_IDLE (DS_IDLE),
    .DS_WAKE (DS_WAKE)
  ) u_pwr_fsm (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_any_req  (w_any_req),
    .i_sd_req   (sd_req),
    .o_state    (w_state),
    .o_ls       (ls),
    .o_ds       (ds),
    .o_sd       (sd),
    .o_mem_lost (mem_lost)
  );

  assign w_active   = (w_state == PWR_ACTIVE);
  assign w_any_req  = c0_req | c1_req;
  // Masked writes still conflict: the mask is not inspected on purpose
  assign w_conflict = c0_req & c1_req & (c0_addr == c1_addr) & (c0_we | c1_we);
  assign c0_gnt     = w_active & c0_req & (~w_conflict | ~r_rr_ptr);
  assign c1_gnt     = w_active & c1_req & (~w_conflict |  r_rr_ptr);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rr_ptr  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rwa     <= 1'b0;
      r_rwb     <= 1'b0;
      r_adra    <= '0;
      r_adrb    <= '0;
      r_da      <= '0;
      r_db      <= '0;
      r_wma     <= '0;
      r_wmb     <= '0;
    end else begin
      r_rr_ptr  <= r_rr_ptr ^ (w_active & w_conflict);
      r_rvalid0 <= c0_gnt & ~c0_we;
      r_rvalid1 <= c1_gnt & ~c1_we;
      if (c0_gnt) begin
        r_rwa  <= c0_we;
        r_adra <= c0_addr;
        r_da   <= c0_wdata;
        r_wma  <= c0_wmask;
      end
      if (c1_gnt) begin
        r_rwb  <= c1_we;
        r_adrb <= c1_addr;
        r_db   <= c1_wdata;
        r_wmb  <= c1_wmask;
      end
    end
  end

  // Idle ports replay the last access so the macro pins do not toggle
  assign mea   = c0_gnt;
  assign rwa   = c0_gnt ? c0_we    : r_rwa;
  assign wadra = c0_gnt ? c0_addr  : r_adra;
  assign radra = wadra;
  assign da    = c0_gnt ? c0_wdata : r_da;
  assign wma   = c0_gnt ? c0_wmask : r_wma;

  assign meb   = c1_gnt;
  assign rwb   = c1_gnt ? c1_we    : r_rwb;
  assign wadrb = c1_gnt ? c1_addr  : r_adrb;
  assign radrb = wadrb;
  assign db    = c1_gnt ? c1_wdata : r_db;
  assign wmb   = c1_gnt ? c1_wmask : r_wmb;

  assign c0_rvalid = r_rvalid0;
  assign c1_rvalid = r_rvalid1;
  assign c0_rdata  = qa;
  assign c1_rdata  = qb;
  assign pwr_state = w_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_2p_arb_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_2p_arb_ctrl : directed bench with read-data scoreboard         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_mem_2p_arb_ctrl;

  logic       clk, arst_n;
  logic       c0_req, c0_we, c1_req, c1_we, sd_req;
  logic [4:0] c0_addr, c1_addr;
  logic [7:0] c0_wdata, c0_wmask, c1_wdata, c1_wmask;
  logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, mem_lost;
  logic [7:0] c0_rdata, c1_rdata;
  logic [2:0] pwr_state;
  logic       mea, rwa, meb, rwb, ls, ds, sd;
  logic [4:0] wadra, radra, wadrb, radrb;
  logic [7:0] da, wma, db, wmb, qa, qb;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] mem [0:31];

  mem_2p_arb_ctrl dut (
    .clk(clk), .arst_n(arst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_wmask(c0_wmask), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_wmask(c1_wmask), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .sd_req(sd_req), .mem_lost(mem_lost), .pwr_state(pwr_state),
    .mea(mea), .rwa(rwa), .wadra(wadra), .radra(radra), .da(da), .wma(wma),
    .meb(meb), .rwb(rwb), .wadrb(wadrb), .radrb(radrb), .db(db), .wmb(wmb),
    .qa(qa), .qb(qb), .ls(ls), .ds(ds), .sd(sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2-port SRAM: 1-cycle read, wm bit = 1 keeps the old bit
  initial for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
  always @(posedge clk) begin
    if (mea) begin
      if (rwa) mem[wadra] <= (mem[wadra] & wma) | (da & ~wma);
      else     qa <= mem[radra];
    end
    if (meb) begin
      if (rwb) mem[wadrb] <= (mem[wadrb] & wmb) | (db & ~wmb);
      else     qb <= mem[radrb];
    end
    if (sd) begin
      qa <= 8'h00;
      qb <= 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0; c0_wmask = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0; c1_wmask = '0;
  endtask

  // Scoreboard monitor: every rvalid pops the expected read data
  always @(negedge clk) begin
    if (c0_rvalid) begin
      if (q0.size() == 0) chk("c0_rvalid_unexpected", 32'(c0_rvalid), 0);
      else                chk("c0_rdata", 32'(c0_rdata), 32'(q0.pop_front()));
    end
    if (c1_rvalid) begin
      if (q1.size() == 0) chk("c1_rvalid_unexpected", 32'(c1_rvalid), 0);
      else                chk("c1_rdata", 32'(c1_rdata), 32'(q1.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    arst_n = 0; sd_req = 0; qa = '0; qb = '0; clr();
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_state", 32'(pwr_state), 0);
    chk("rst_ls", 32'(ls), 0);
    chk("rst_ds", 32'(ds), 0);
    chk("rst_sd", 32'(sd), 0);
    chk("rst_mem_lost", 32'(mem_lost), 0);
    chk("rst_rvalid", 32'({c0_rvalid, c1_rvalid}), 0);
    nxt(); arst_n = 1;

    // c0 write 3 <- 5A, c1 read 7, no contention
    c0_req = 1; c0_we = 1; c0_addr = 5'd3; c0_wdata = 8'h5A; c0_wmask = 8'h00;
    c1_req = 1; c1_we = 0; c1_addr = 5'd7; q1.push_back(8'hA7);
    @(negedge clk);
    chk("t1_gnt", 32'({c0_gnt, c1_gnt}), 32'b11);
    chk("t1_porta", 32'({rwa, wadra, da}), 32'({1'b1, 5'd3, 8'h5A}));
    chk("t1_portb", 32'({rwb, radrb}), 32'({1'b0, 5'd7}));
    nxt(); clr();
    @(negedge clk);
    chk("t1_hold", 32'({mea, wadra, da}), 32'({1'b0, 5'd3, 8'h5A}));
    nxt();
    c0_req = 1; c0_addr = 5'd3; q0.push_back(8'h5A);
    @(negedge clk); chk("t1_rd_gnt", 32'(c0_gnt), 1);
    nxt(); clr();

    // masked write: keep high nibble of 5A, low nibble from FF -> 5F
    c0_req = 1; c0_we = 1; c0_addr = 5'd3; c0_wdata = 8'hFF; c0_wmask = 8'hF0;
    @(negedge clk); chk("mask_wr_gnt", 32'(c0_gnt), 1);
    nxt(); c0_we = 0; q0.push_back(8'h5F);
    @(negedge clk); chk("mask_rd_gnt", 32'(c0_gnt), 1);
    nxt(); clr();

    // write/write to addr 4, rr_ptr=0; c0 mask all-ones still conflicts
    c0_req = 1; c0_we = 1; c0_addr = 5'd4; c0_wdata = 8'h11; c0_wmask = 8'hFF;
    c1_req = 1; c1_we = 1; c1_addr = 5'd4; c1_wdata = 8'h22; c1_wmask = 8'h00;
    @(negedge clk); chk("ww_cyc0_gnt", 32'({c0_gnt, c1_gnt}), 32'b10);
    nxt(); c0_req = 0;
    @(negedge clk); chk("ww_cyc1_gnt", 32'({c0_gnt, c1_gnt}), 32'b01);
    nxt(); clr();
    c0_req = 1; c0_addr = 5'd4; q0.push_back(8'h22);
    @(negedge clk); chk("ww_rd_gnt", 32'(c0_gnt), 1);
    nxt(); clr();

    // read/write to addr 9, rr_ptr=1: c1 write first, c0 reads new data
    c0_req = 1; c0_we = 0; c0_addr = 5'd9; q0.push_back(8'h99);
    c1_req = 1; c1_we = 1; c1_addr = 5'd9; c1_wdata = 8'h99; c1_wmask = 8'h00;
    @(negedge clk); chk("rw_cyc0_gnt", 32'({c0_gnt, c1_gnt}), 32'b01);
    nxt(); c1_req = 0;
    @(negedge clk); chk("rw_cyc1_gnt", 32'({c0_gnt, c1_gnt}), 32'b10);
    nxt(); clr();

    // two reads of the same address are both granted
    c0_req = 1; c0_addr = 5'd7; c1_req = 1; c1_addr = 5'd7;
    q0.push_back(8'hA7); q1.push_back(8'hA7);
    @(negedge clk); chk("rr_same_gnt", 32'({c0_gnt, c1_gnt}), 32'b11);
    nxt(); clr();

    // idle cycle 0 now; LS after 8 idle cycles, wake on req at cycle 20
    repeat (7) nxt();
    @(negedge clk); chk("ls_cyc7", 32'({pwr_state, ls}), 32'({3'd0, 1'b0}));
    nxt();
    @(negedge clk); chk("ls_cyc8", 32'({pwr_state, ls}), 32'({3'd1, 1'b1}));
    repeat (12) nxt();
    c0_req = 1; c0_addr = 5'd3; q0.push_back(8'h5F);
    @(negedge clk); chk("ls_req_cyc20", 32'({pwr_state, c0_gnt}), 32'({3'd1, 1'b0}));
    nxt();
    @(negedge clk); chk("ls_wake_cyc21", 32'({pwr_state, ls, c0_gnt}), 32'({3'd4, 1'b0, 1'b0}));
    nxt();
    @(negedge clk); chk("ls_gnt_cyc22", 32'({pwr_state, c0_gnt}), 32'({3'd0, 1'b1}));
    nxt(); clr();

    // DS after LS_IDLE+DS_IDLE = 72 idle cycles
    repeat (71) nxt();
    @(negedge clk); chk("ds_cyc71", 32'({pwr_state, ls, ds}), 32'({3'd1, 1'b1, 1'b0}));
    nxt();
    @(negedge clk); chk("ds_cyc72", 32'({pwr_state, ls, ds}), 32'({3'd2, 1'b0, 1'b1}));
    repeat (2) nxt();
    c1_req = 1; c1_we = 1; c1_addr = 5'd10; c1_wdata = 8'h3C; c1_wmask = 8'h00;
    @(negedge clk); chk("ds_req_gnt", 32'(c1_gnt), 0);
    repeat (4) nxt();
    @(negedge clk); chk("ds_wake_last", 32'({pwr_state, c1_gnt}), 32'({3'd4, 1'b0}));
    nxt();
    @(negedge clk); chk("ds_gnt", 32'({c1_gnt, meb, rwb}), 32'b111);
    nxt(); clr();

    // sd_req with a request pending: grant first, SD only once idle
    c0_req = 1; c0_addr = 5'd4; q0.push_back(8'h22); sd_req = 1;
    @(negedge clk); chk("sd_pend_gnt", 32'({pwr_state, c0_gnt}), 32'({3'd0, 1'b1}));
    nxt(); c0_req = 0;
    @(negedge clk); chk("sd_pend_active", 32'(pwr_state), 0);
    nxt();
    @(negedge clk); chk("sd_entry", 32'({pwr_state, sd, ls, ds}), 32'({3'd3, 3'b100}));
    c0_req = 1; c0_addr = 5'd10;
    nxt();
    @(negedge clk);
    chk("sd_ignore_req", 32'({pwr_state, c0_gnt, mea}), 32'({3'd3, 2'b00}));
    chk("sd_qa_zero", 32'(c0_rdata), 0);
    c0_req = 0; sd_req = 0;
    nxt();
    @(negedge clk); chk("sd_exit_lost", 32'({pwr_state, mem_lost, sd}), 32'({3'd4, 2'b10}));
    nxt();
    @(negedge clk); chk("sd_lost_pulse", 32'(mem_lost), 0);
    repeat (2) nxt();
    @(negedge clk); chk("sd_wake_last", 32'(pwr_state), 4);
    nxt();
    @(negedge clk); chk("sd_wake_done", 32'(pwr_state), 0);

    // async reset in the middle of WAKE
    sd_req = 1; nxt(); sd_req = 0; nxt();
    chk("rst_wake_pre", 32'({pwr_state, mem_lost}), 32'({3'd4, 1'b1}));
    arst_n = 0; #1;
    chk("rst_wake_post", 32'({pwr_state, mem_lost, ls, ds, sd}), 0);
    nxt(); arst_n = 1;

    // async reset drops a pending rvalid
    c0_req = 1; c0_addr = 5'd3;
    @(negedge clk); chk("rst_rd_gnt", 32'(c0_gnt), 1);
    @(posedge clk); #1; clr(); arst_n = 0; #1;
    chk("rst_rvalid_drop", 32'(c0_rvalid), 0);
    nxt(); arst_n = 1; nxt();

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_2p_arb_ctrl.md
Name: mem_2p_arb_ctrl

Overview:
Arbiter and power sequencer in front of the two-port synchronous SRAM wrapper (calypto_mem_2p, WT=0). Client 0 is mapped to port A and client 1 to port B. The block blocks same-address write/write and read/write contentions before they reach the macro, so the macro's X-corruption paths are never exercised. It also drives the ls/ds/sd power pins from idle counters and a shutdown request, and sequences wake-up before any grant.

Parameters:
AW, 5, memory address width
DW, 8, memory data width
LS_IDLE, 8, consecutive idle cycles in ACTIVE before entering LS
DS_IDLE, 64, consecutive idle cycles in LS before entering DS
DS_WAKE, 4, cycles spent in WAKE after leaving DS or SD

Ports:
clk  in  1  single clock; posedge; also feeds clka and clkb of the memory
arst_n  in  1  asynchronous active-low reset
c0_req / c1_req  in  1  client request; held stable until granted
c0_we / c1_we  in  1  1 = write, 0 = read
c0_addr / c1_addr  in  AW  address
c0_wdata / c1_wdata  in  DW  write data
c0_wmask / c1_wmask  in  DW  bit = 1 suppresses the write of that bit
c0_gnt / c1_gnt  out  1  combinational grant; the access is issued this cycle
c0_rvalid / c1_rvalid  out  1  read data valid, registered
c0_rdata / c1_rdata  out  DW  = qa / qb pass-through
sd_req  in  1  level request for shutdown
mem_lost  out  1  one-cycle pulse on exit from SD (memory contents are X)
pwr_state  out  3  current FSM state code
mea, rwa, wadra, radra, da, wma  out  memory port A controls
meb, rwb, wadrb, radrb, db, wmb  out  memory port B controls
qa, qb  in  DW  memory read data
ls, ds, sd  out  1  memory power pins, registered

Behaviour:
- FSM states: ACTIVE=0, LS=1, DS=2, SD=3, WAKE=4. Reset state is ACTIVE.
- Reset values: idle_cnt=0, wake_cnt=0, rr_ptr=0, rvalid=0, ls=ds=sd=0, mem_lost=0.
- Grants:
  - Grants are only possible in ACTIVE. In every other state gnt=0, mea=meb=0 and requests wait.
- Contention rule: conflict = c0_req & c1_req & (c0_addr==c1_addr) & (c0_we|c1_we).
  - A write with an all-ones mask still counts as a conflict (deliberately conservative).
  - Two reads to the same address are not a conflict; both are granted.
  - On conflict, only the rr_ptr client is granted (0 → c0, 1 → c1). rr_ptr toggles after every conflict cycle.
  - The loser is granted no later than the next cycle if its request is still held.
- Memory drive:
  - me = gnt, rw = we.
  - wadr = radr = addr.
  - d = wdata, wm = wmask.
  - With me=0, the data and address outputs hold their last values (no toggling).
- Read latency: rvalid rises 1 cycle after a read grant; rdata = q in that cycle. Writes return no response.
- ACTIVE:
  - idle_cnt counts cycles with no req; it clears on any req.
  - When idle_cnt reaches LS_IDLE → LS (ls=1 from the next cycle).
  - sd_req has priority over the LS transition: → SD.
- LS:
  - Any req → WAKE with wake_cnt=1 (LS exit is 1 cycle).
  - DS_IDLE idle cycles → DS (ls=0, ds=1).
  - sd_req → SD.
- DS:
  - Any req → WAKE with wake_cnt=DS_WAKE.
  - sd_req → SD.
- SD:
  - sd=1 and ls=ds=0.
  - When sd_req is low → WAKE with wake_cnt=DS_WAKE, and mem_lost pulses in the first WAKE cycle.
  - Requests are ignored while sd_req is high.
- WAKE: all power pins 0; wake_cnt decrements; at 1 → ACTIVE (idle_cnt cleared).
- sd_req in ACTIVE with requests pending: SD is entered only when no request is present that cycle. Outstanding rvalids still complete.
- Power entry never coincides with me=1. There is always a cycle with me=0 before ls/ds/sd rise.
- Reset mid-operation: all state is cleared asynchronously and a pending rvalid is dropped. The client must re-request.

Decomposition:
- Package mem_2p_ctrl_pkg holds the state enum (3-bit codes above) and the PWR_ACTIVE..PWR_WAKE constants.
- One sub-module, mem_2p_pwr_fsm, holds the power FSM, idle/wake counters, ls/ds/sd registers and mem_lost.
- The top level holds the arbitration, rr_ptr, memory muxing and rvalid registers.

Test Plan:
- c0 write 0x5A to addr 3 and c1 read addr 7, same cycle → both gnt=1; c1_rvalid next cycle with the prior mem[7]. A later c0 read of addr 3 → 0x5A.
- c0 write and c1 write, both addr 4, rr_ptr=0:
  - cycle 0: c0 granted only;
  - cycle 1: c1 granted;
  - mem[4] = c1 data;
  - no "Write Conflict" display.
- c0 read addr 9 while c1 writes addr 9 (rr_ptr=1) → c1 granted first; c0 granted next cycle and reads the new data. No "Read Conflict" display.
- No requests for 8 cycles → ls=1. A c0_req at cycle 20 → 1 WAKE cycle, gnt at cycle 22.
- Idle for LS_IDLE+DS_IDLE cycles → ds=1. A req then → gnt exactly DS_WAKE+1 cycles later.
- sd_req=1 while idle → sd=1 and qa=0. sd_req=0 → mem_lost pulse, ACTIVE after DS_WAKE cycles, and reads return X. Assert arst_n=0 mid-WAKE → ACTIVE with all outputs 0.
